// File: rtl/issue_ctrl_pkg.sv
// Shared processor definitions used by decode, issue and execute.
package issue_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int OPCODE_W   = 5;

  typedef enum logic [0:0] {
    S_RUN     = 1'b0,
    S_MC_BUSY = 1'b1
  } issue_state_t;

endpackage

// File: rtl/issue_ctrl_reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register, plus two
// read ports that report a RAW hazard against the registered pending bits.
// x0 is never tracked, so its bit is tied low.
module reg_scoreboard
  import issue_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic                  rs1_en_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic                  rs2_en_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  hazard_o
);

  logic [NUM_REGS-1:0] pending;

  assign pending[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
      localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(gi);
      logic pending_reg;
      logic pending_next;

      // Flush beats everything; a new writer beats a retiring one (it is younger).
      always_comb begin
        pending_next = pending_reg;
        if (flush_i) begin
          pending_next = 1'b0;
        end else if (set_en_i && (set_addr_i == IDX)) begin
          pending_next = 1'b1;
        end else if (clr_en_i && (clr_addr_i == IDX)) begin
          pending_next = 1'b0;
        end
      end

      // Pending bit storage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pending_reg <= 1'b0;
        end else begin
          pending_reg <= pending_next;
        end
      end

      assign pending[gi] = pending_reg;
    end
  endgenerate

  // Hazard uses only the registered bits: no same-cycle writeback bypass.
  always_comb begin
    hazard_o = (rs1_en_i && (rs1_addr_i != '0) && pending[rs1_addr_i]) ||
               (rs2_en_i && (rs2_addr_i != '0) && pending[rs2_addr_i]);
  end

endmodule

// File: rtl/issue_ctrl.sv
// Issue controller between decode and execute: gates issue on scoreboard
// hazards, multi-cycle occupancy and flush, and registers the issued op.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int MC_LATENCY = 4,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [OPCODE_W-1:0]   id_opcode_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  id_writes_rd_i,
  input  logic                  id_multicycle_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic                  flush_i,
  output logic                  id_ready_o,
  output logic                  stall_o,
  output logic                  ex_valid_o,
  output logic [OPCODE_W-1:0]   ex_opcode_o,
  output logic [REG_ADDR_W-1:0] ex_rd_addr_o,
  output logic                  ex_busy_o
);

  localparam int CNT_W = $clog2(MC_LATENCY + 1);

  issue_state_t     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hazard;
  logic             accept;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .set_en_i   (accept && id_writes_rd_i && (id_rd_addr_i != '0)),
    .set_addr_i (id_rd_addr_i),
    .clr_en_i   (wb_valid_i && (wb_rd_addr_i != '0)),
    .clr_addr_i (wb_rd_addr_i),
    .rs1_en_i   (id_uses_rs1_i),
    .rs1_addr_i (id_rs1_addr_i),
    .rs2_en_i   (id_uses_rs2_i),
    .rs2_addr_i (id_rs2_addr_i),
    .hazard_o   (hazard)
  );

  // State register and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next state: a multi-cycle issue holds execute until the counter reaches 1.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (flush_i) begin
      state_next = S_RUN;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_RUN: begin
          if (accept && id_multicycle_i) begin
            state_next = S_MC_BUSY;
            cnt_next   = CNT_W'(MC_LATENCY - 1);
          end
        end
        S_MC_BUSY: begin
          if (cnt_reg <= CNT_W'(1)) begin
            state_next = S_RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs: accept/stall handshake and busy flag.
  always_comb begin
    accept     = id_valid_i && !hazard && (state_reg == S_RUN) && !flush_i;
    id_ready_o = accept;
    stall_o    = id_valid_i && !accept;
    ex_busy_o  = (state_reg == S_MC_BUSY);
  end

  // Execute-stage register: valid pulses per issue, fields hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o   <= 1'b0;
      ex_opcode_o  <= '0;
      ex_rd_addr_o <= '0;
    end else begin
      ex_valid_o <= accept;
      if (accept) begin
        ex_opcode_o  <= id_opcode_i;
        ex_rd_addr_o <= id_rd_addr_i;
      end
    end
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Issue/scheduling controller between decode and the execute stage. It decides each cycle whether the decoded instruction may enter execute, using three inputs: a register scoreboard (pending writes), the occupancy of a multi-cycle ALU operation, and flush. It drives a registered valid/opcode/rd to execute and exposes a stall to the front end.

Parameters:
MC_LATENCY, 4, cycles a multi-cycle op occupies execute (>=2)
NUM_REGS, 32, architectural registers; x0 is never tracked

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
id_valid_i  input  1  decode holds a valid instruction
id_opcode_i  input  5  decoded opcode
id_rs1_addr_i  input  5  source 1 register
id_rs2_addr_i  input  5  source 2 register
id_rd_addr_i  input  5  destination register
id_uses_rs1_i  input  1  instruction reads rs1
id_uses_rs2_i  input  1  instruction reads rs2
id_writes_rd_i  input  1  instruction writes rd
id_multicycle_i  input  1  op needs MC_LATENCY cycles in execute
wb_valid_i  input  1  writeback retiring a register write
wb_rd_addr_i  input  5  register retired
flush_i  input  1  squash issue and in-flight state
id_ready_o  output  1  instruction accepted this cycle (combinational)
stall_o  output  1  id_valid_i & ~id_ready_o
ex_valid_o  output  1  registered issue pulse to execute
ex_opcode_o  output  5  registered opcode to execute
ex_rd_addr_o  output  5  registered rd to execute
ex_busy_o  output  1  multi-cycle op occupying execute

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: ex_valid_o=0, ex_opcode_o=0, ex_rd_addr_o=0, ex_busy_o=0, all pending bits=0, counter=0, state=S_RUN.
- Hazard: raised when id_uses_rs1_i & pending[rs1] & rs1!=0, or when the same condition holds for rs2.
- Scoreboard timing: uses registered pending bits only. No same-cycle writeback bypass; a register retired in cycle N becomes readable at issue in cycle N+1.
- Accept condition: id_ready_o = id_valid_i & ~hazard & (state==S_RUN) & ~flush_i.
- Issue: on accept, in the next cycle ex_valid_o=1, ex_opcode_o=id_opcode_i and ex_rd_addr_o=id_rd_addr_i. Latency is 1 cycle.
- No issue: ex_valid_o=0. ex_opcode_o and ex_rd_addr_o hold their previous values.
- Scoreboard set: on accept with id_writes_rd_i and rd!=0, set pending[rd].
- Scoreboard clear: on wb_valid_i with wb_rd_addr_i!=0, clear pending[wb_rd_addr_i].
- Set and clear of the same register in one cycle: set wins, because the new writer is younger.
- x0 is never set, and writeback to x0 is ignored.
- FSM state S_RUN: on accept with id_multicycle_i, load counter with MC_LATENCY-1 and go to S_MC_BUSY.
- FSM state S_MC_BUSY: ex_busy_o=1 and no accept. Counter decrements each cycle. At counter==1, return to S_RUN next cycle, so a new issue is possible MC_LATENCY cycles after the multi-cycle issue.
- Counter width: $clog2(MC_LATENCY+1). The counter never wraps below 0.
- Flush: suppresses accept that cycle and clears all pending bits. Next cycle: state=S_RUN, counter=0, ex_valid_o=0.
- Flush with wb_valid_i in the same cycle: flush dominates, and all pending bits are cleared.
- Reset mid-operation: reset asserted during S_MC_BUSY or with pending bits set returns everything immediately to reset values.
- Constraint: id_valid_i may stay high across stalls. Decode must hold its fields stable until id_ready_o.

Decomposition:
- Shared processor package, constants: REG_ADDR_W=5 and OPCODE_W=5, shared with execute.
- Shared processor package, type: typedef enum {S_RUN, S_MC_BUSY} issue_state_t.
- Sub-module reg_scoreboard: owns the pending bit-vector, set/clear/flush priority, and the two read ports returning a hazard flag.
- The FSM and counter stay in issue_ctrl.

Test Plan:
- Scoreboard set and writeback clear:
  - Stimulus: issue writes x5; next cycle present an instruction reading rs1=x5.
  - Required: stall_o=1 until wb_valid_i with rd=5 arrives, then id_ready_o=1 one cycle after the writeback; ex_valid_o pulses the cycle after that.
- x0 never stalls:
  - Stimulus: issue writes x0; next instruction reads rs1=x0, rs2=x0.
  - Required: no stall; back-to-back ex_valid_o pulses.
- Multi-cycle occupancy:
  - Stimulus: MC_LATENCY=4; issue a multi-cycle op at cycle 0 with an independent instruction valid at cycle 1.
  - Required: ex_busy_o=1 for cycles 1-3; second accept at cycle 4; ex_valid_o high at cycles 1 and 5.
- Simultaneous set and clear:
  - Stimulus: x7 pending; same cycle, wb_valid_i for rd=7 and accept of a new writer of x7.
  - Required: pending[7] stays 1; a reader of x7 still stalls.
- Flush:
  - Stimulus: during S_MC_BUSY with x3 and x9 pending, assert flush_i for 1 cycle.
  - Required: next cycle ex_busy_o=0, no pending bits set, readers of x3 and x9 issue immediately, ex_valid_o=0 in the flush+1 cycle.
- Async reset:
  - Stimulus: deassert rst_n mid-busy, asynchronously between clock edges.
  - Required: all outputs 0 without waiting for a clock edge; after release, the first valid independent instruction is accepted.
